// File: rtl/memory_stage.sv
// Y86-64 data-memory stage: decodes icode into a word read or write, combinational
// read path, synchronous write with out-of-range suppression and full clear on reset.
module memory_stage #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic [63:0] valM,
  output logic        dmem_error,
  output logic [63:0] memory_address,
  output logic [63:0] datamem
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [63:0]   mem_q [MEM_WORDS];
  logic          is_read;
  logic          is_write;
  logic [63:0]   access_addr;
  logic [63:0]   wr_data;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic [63:0]   rd_word;
  logic          wr_en;

  always_comb begin
    is_read     = 1'b0;
    is_write    = 1'b0;
    access_addr = '0;
    wr_data     = valA;
    unique case (icode)
      4'h4: begin is_write = 1'b1; access_addr = valE; end
      4'h5: begin is_read  = 1'b1; access_addr = valE; end
      4'h8: begin is_write = 1'b1; access_addr = valE; wr_data = valP; end
      4'h9: begin is_read  = 1'b1; access_addr = valA; end
      4'hA: begin is_write = 1'b1; access_addr = valE; end
      4'hB: begin is_read  = 1'b1; access_addr = valA; end
      default: ;
    endcase
  end

  // Whole 64-bit address is compared so high garbage bits never alias onto a valid word.
  assign in_range = access_addr < 64'(MEM_WORDS);
  assign word_idx = access_addr[AW-1:0];
  assign rd_word  = in_range ? mem_q[word_idx] : '0;
  assign wr_en    = is_write && in_range;

  always_comb begin
    dmem_error     = (is_read || is_write) && !in_range;
    memory_address = access_addr;
    datamem        = (is_read || is_write) ? rd_word : '0;
    valM           = is_read ? rd_word : '0;
  end

  // Reset wins over a write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[word_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: each step queues the expected outputs and
// the sampled outputs, and each scenario task compares its own queue entries.
module tb_memory_stage;

  logic        clk;
  logic        reset;
  logic [3:0]  icode;
  logic [63:0] valA;
  logic [63:0] valE;
  logic [63:0] valP;
  logic [63:0] valM;
  logic        dmem_error;
  logic [63:0] memory_address;
  logic [63:0] datamem;

  typedef struct packed {
    logic [63:0] val_m;
    logic [63:0] addr;
    logic [63:0] dm;
    logic        err;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  memory_stage #(.MEM_WORDS(1024)) dut (
    .clk(clk),
    .reset(reset),
    .icode(icode),
    .valA(valA),
    .valE(valE),
    .valP(valP),
    .valM(valM),
    .dmem_error(dmem_error),
    .memory_address(memory_address),
    .datamem(datamem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one instruction at the falling edge, queue the expectation and the sampled outputs.
  task automatic step(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                      input logic [63:0] p, input obs_t expected);
    @(negedge clk);
    icode = ic;
    valA  = a;
    valE  = e;
    valP  = p;
    exp_q.push_back(expected);
    #1;
    obs_q.push_back('{valM, memory_address, datamem, dmem_error});
  endtask

  task automatic test_reset;
    obs_t e, o;
    @(negedge clk);
    reset = 1'b1;
    icode = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(4'h5, 64'd15, 64'd2, 64'd10, '{64'd0, 64'd2, 64'd0, 1'b0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL reset: got valM=%h addr=%h datamem=%h err=%b, expected valM=%h addr=%h datamem=%h err=%b",
                 o.val_m, o.addr, o.dm, o.err, e.val_m, e.addr, e.dm, e.err);
      end else $display("[TB] reset: valM=%h addr=%h datamem=%h err=%b ok", o.val_m, o.addr, o.dm, o.err);
    end
  endtask

  task automatic test_read_write;
    obs_t e, o;
    // Before the write edge datamem still shows the old word.
    step(4'h4, 64'd15, 64'd2, 64'd0, '{64'd0, 64'd2, 64'd0, 1'b0});
    step(4'h5, 64'd0, 64'd2, 64'd0, '{64'd15, 64'd2, 64'd15, 1'b0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL read_write: got valM=%h addr=%h datamem=%h err=%b, expected valM=%h addr=%h datamem=%h err=%b",
                 o.val_m, o.addr, o.dm, o.err, e.val_m, e.addr, e.dm, e.err);
      end else $display("[TB] read_write: valM=%h addr=%h datamem=%h err=%b ok", o.val_m, o.addr, o.dm, o.err);
    end
  endtask

  task automatic test_call_ret_push_pop;
    obs_t e, o;
    step(4'h8, 64'd0, 64'd8, 64'd10, '{64'd0, 64'd8, 64'd0, 1'b0});
    step(4'h9, 64'd8, 64'd0, 64'd0, '{64'd10, 64'd8, 64'd10, 1'b0});
    step(4'hA, 64'd7, 64'd1, 64'd0, '{64'd0, 64'd1, 64'd0, 1'b0});
    step(4'hB, 64'd1, 64'd0, 64'd0, '{64'd7, 64'd1, 64'd7, 1'b0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL call_ret_push_pop: got valM=%h addr=%h datamem=%h err=%b, expected valM=%h addr=%h datamem=%h err=%b",
                 o.val_m, o.addr, o.dm, o.err, e.val_m, e.addr, e.dm, e.err);
      end else $display("[TB] call_ret_push_pop: valM=%h addr=%h datamem=%h err=%b ok", o.val_m, o.addr, o.dm, o.err);
    end
  endtask

  task automatic test_error;
    obs_t e, o;
    step(4'h5, 64'd0, 64'd1023, 64'd0, '{64'd0, 64'd1023, 64'd0, 1'b0});
    step(4'h4, 64'd99, 64'd2000, 64'd0, '{64'd0, 64'd2000, 64'd0, 1'b1});
    step(4'h5, 64'd0, 64'd2000, 64'd0, '{64'd0, 64'd2000, 64'd0, 1'b1});
    step(4'h5, 64'd0, 64'd1024, 64'd0, '{64'd0, 64'd1024, 64'd0, 1'b1});
    step(4'h4, 64'd55, 64'h8000_0000_0000_0002, 64'd0, '{64'd0, 64'h8000_0000_0000_0002, 64'd0, 1'b1});
    step(4'h5, 64'd0, 64'd2, 64'd0, '{64'd15, 64'd2, 64'd15, 1'b0});
    step(4'h4, 64'd77, 64'd1023, 64'd0, '{64'd0, 64'd1023, 64'd0, 1'b0});
    step(4'hB, 64'd1023, 64'd0, 64'd0, '{64'd77, 64'd1023, 64'd77, 1'b0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL error: got valM=%h addr=%h datamem=%h err=%b, expected valM=%h addr=%h datamem=%h err=%b",
                 o.val_m, o.addr, o.dm, o.err, e.val_m, e.addr, e.dm, e.err);
      end else $display("[TB] error: valM=%h addr=%h datamem=%h err=%b ok", o.val_m, o.addr, o.dm, o.err);
    end
  endtask

  task automatic test_no_access;
    obs_t e, o;
    step(4'h3, 64'd44, 64'd2, 64'd0, '{64'd0, 64'd0, 64'd0, 1'b0});
    step(4'h7, 64'd2, 64'd2000, 64'd9, '{64'd0, 64'd0, 64'd0, 1'b0});
    step(4'hF, 64'd1, 64'd1, 64'd1, '{64'd0, 64'd0, 64'd0, 1'b0});
    step(4'h5, 64'd0, 64'd2, 64'd0, '{64'd15, 64'd2, 64'd15, 1'b0});
    step(4'h5, 64'd0, 64'd1, 64'd0, '{64'd7, 64'd1, 64'd7, 1'b0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL no_access: got valM=%h addr=%h datamem=%h err=%b, expected valM=%h addr=%h datamem=%h err=%b",
                 o.val_m, o.addr, o.dm, o.err, e.val_m, e.addr, e.dm, e.err);
      end else $display("[TB] no_access: valM=%h addr=%h datamem=%h err=%b ok", o.val_m, o.addr, o.dm, o.err);
    end
  endtask

  task automatic test_reset_priority;
    obs_t e, o;
    @(negedge clk);
    reset = 1'b1;
    icode = 4'h4;
    valA  = 64'd5;
    valE  = 64'd3;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    icode = 4'h0;
    step(4'h5, 64'd0, 64'd2, 64'd0, '{64'd0, 64'd2, 64'd0, 1'b0});
    step(4'h5, 64'd0, 64'd3, 64'd0, '{64'd0, 64'd3, 64'd0, 1'b0});
    step(4'hB, 64'd1023, 64'd0, 64'd0, '{64'd0, 64'd1023, 64'd0, 1'b0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL reset_priority: got valM=%h addr=%h datamem=%h err=%b, expected valM=%h addr=%h datamem=%h err=%b",
                 o.val_m, o.addr, o.dm, o.err, e.val_m, e.addr, e.dm, e.err);
      end else $display("[TB] reset_priority: valM=%h addr=%h datamem=%h err=%b ok", o.val_m, o.addr, o.dm, o.err);
    end
  endtask

  initial begin
    reset = 1'b0;
    icode = 4'h0;
    valA  = '0;
    valE  = '0;
    valP  = '0;
    test_reset();
    test_read_write();
    test_call_ret_push_pop();
    test_error();
    test_no_access();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
